// File: rtl/dcache_miss_ctrl_if.sv
// rtl/dcache_miss_ctrl_if.sv - CPU-side and memory-side signal bundle of the data cache miss controller
interface dcache_miss_ctrl_if #(
  parameter int LINE_W = 256
);
  logic              p1_req_i;
  logic              p1_write_i;
  logic [31:0]       p1_addr_i;
  logic [31:0]       p1_data_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - direct-mapped write-back write-allocate data cache with miss FSM
module dcache_miss_ctrl #(
  parameter  int LINES  = 32,
  parameter  int LINE_W = 256,
  localparam int IDX_W  = $clog2(LINES),
  localparam int TAG_W  = 32 - IDX_W - 5
) (
  input logic clk_i,
  input logic rst_i,
  dcache_miss_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL_DONE} state_t;

  state_t            state_q, state_n;
  logic [LINE_W-1:0] data_arr [LINES];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]  valid_q, dirty_q;
  logic [31:5]       miss_addr_q;
  logic              rst_q;

  logic              en_q, en_n, wr_q, wr_n;
  logic [31:0]       addr_q, addr_n;
  logic [LINE_W-1:0] wdata_q, wdata_n;

  logic              req_ok, hit, miss;
  logic [IDX_W-1:0]  req_idx, m_idx;
  logic [TAG_W-1:0]  req_tag, m_tag;
  logic [2:0]        word_sel;

  // Requests are ignored during reset and the cycle after it so stall/data stay quiet there.
  assign req_ok   = bus.p1_req_i & ~rst_i & ~rst_q;
  assign req_idx  = bus.p1_addr_i[4+IDX_W:5];
  assign req_tag  = bus.p1_addr_i[31:5+IDX_W];
  assign word_sel = bus.p1_addr_i[4:2];
  assign m_idx    = miss_addr_q[4+IDX_W:5];
  assign m_tag    = miss_addr_q[31:5+IDX_W];

  assign hit  = req_ok & valid_q[req_idx] & (tag_arr[req_idx] == req_tag);
  assign miss = req_ok & ~hit;

  assign bus.p1_stall_o   = (state_q != IDLE) | ((state_q == IDLE) & miss);
  assign bus.p1_data_o    = (state_q == IDLE && hit && !bus.p1_write_i)
                            ? data_arr[req_idx][{word_sel, 5'b0} +: 32] : 32'h0;
  assign bus.mem_enable_o = en_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = wdata_q;

  // Memory outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_n = state_q;
    en_n    = en_q;
    wr_n    = wr_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          en_n = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_n = WRITEBACK;
            wr_n    = 1'b1;
            addr_n  = {tag_arr[req_idx], req_idx, 5'b0};
            wdata_n = data_arr[req_idx];
          end else begin
            state_n = ALLOCATE;
            wr_n    = 1'b0;
            addr_n  = {req_tag, req_idx, 5'b0};
            wdata_n = '0;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_n = ALLOCATE;
          en_n    = 1'b1;
          wr_n    = 1'b0;
          addr_n  = {m_tag, m_idx, 5'b0};
          wdata_n = '0;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ack_i) begin
          state_n = REFILL_DONE;
          en_n    = 1'b0;
          wr_n    = 1'b0;
          addr_n  = '0;
          wdata_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_addr_q <= '0;
      rst_q       <= 1'b1;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_n;
      rst_q   <= 1'b0;
      en_q    <= en_n;
      wr_q    <= wr_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      if (state_q == IDLE && miss)
        miss_addr_q <= bus.p1_addr_i[31:5];
      if (state_q == IDLE && hit && bus.p1_write_i)
        dirty_q[req_idx] <= 1'b1;
      if (state_q == WRITEBACK && bus.mem_ack_i)
        dirty_q[m_idx] <= 1'b0;
      if (state_q == ALLOCATE && bus.mem_ack_i) begin
        valid_q[m_idx] <= 1'b1;
        dirty_q[m_idx] <= 1'b0;
      end
    end
  end

  // Line payload and tags carry no reset; validity alone says whether they mean anything.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == IDLE && hit && bus.p1_write_i)
        data_arr[req_idx][{word_sel, 5'b0} +: 32] <= bus.p1_data_i;
      if (state_q == ALLOCATE && bus.mem_ack_i) begin
        data_arr[m_idx] <= bus.mem_data_i;
        tag_arr[m_idx]  <= m_tag;
      end
    end
  end
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - directed and randomized bench for dcache_miss_ctrl against a cache/memory model
module tb_dcache_miss_ctrl;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dcache_miss_ctrl_if #(.LINE_W(256)) bus ();
  dcache_miss_ctrl #(.LINES(32), .LINE_W(256)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Model: cache contents as word arrays, memory as a sparse word map.
  logic [31:0] mem_m [int unsigned];
  logic [31:0] c_data [32][8];
  logic [21:0] c_tag  [32];
  bit          c_valid[32];
  bit          c_dirty[32];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    if (mem_m.exists(k)) return mem_m[k];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      c_valid[i] = 0;
      c_dirty[i] = 0;
    end
  endtask

  task automatic ack_after(input int lat, input logic [255:0] line);
    for (int i = 0; i < lat; i++) begin
      chk("wait_stall", bus.p1_stall_o, 1'b1);
      chk("wait_en", bus.mem_enable_o, 1'b1);
      step();
    end
    bus.mem_data_i = line;
    bus.mem_ack_i  = 1'b1;
    step();
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
  endtask

  task automatic access(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                        input int lat, input bit drop_req);
    logic [4:0]   idx = addr[9:5];
    logic [21:0]  tag = addr[31:10];
    logic [2:0]   wsel = addr[4:2];
    logic [255:0] line;
    bit           served = 1;
    bus.p1_req_i = 1'b1; bus.p1_write_i = w; bus.p1_addr_i = addr; bus.p1_data_i = wd;
    #1;
    if (c_valid[idx] && c_tag[idx] == tag) begin
      chk("hit_stall", bus.p1_stall_o, 1'b0);
      chk("hit_no_mem", bus.mem_enable_o, 1'b0);
      if (!w) chk("hit_data", bus.p1_data_o, c_data[idx][wsel]);
    end else begin
      chk("miss_stall", bus.p1_stall_o, 1'b1);
      step();
      if (drop_req) begin
        bus.p1_req_i = 1'b0;
        served = 0;
      end
      if (c_valid[idx] && c_dirty[idx]) begin
        for (int i = 0; i < 8; i++) line[i*32 +: 32] = c_data[idx][i];
        chk("wb_en", bus.mem_enable_o, 1'b1);
        chk("wb_write", bus.mem_write_o, 1'b1);
        chk("wb_addr", bus.mem_addr_o, {c_tag[idx], idx, 5'b0});
        chk("wb_data", bus.mem_data_o, line);
        for (int i = 0; i < 8; i++) mem_m[{c_tag[idx], idx, 3'(i)}] = c_data[idx][i];
        ack_after(lat, '0);
      end
      for (int i = 0; i < 8; i++) line[i*32 +: 32] = mem_rd({tag, idx, 3'(i), 2'b0});
      chk("alloc_en", bus.mem_enable_o, 1'b1);
      chk("alloc_write", bus.mem_write_o, 1'b0);
      chk("alloc_addr", bus.mem_addr_o, {tag, idx, 5'b0});
      ack_after(lat, line);
      chk("refill_stall", bus.p1_stall_o, 1'b1);
      chk("refill_en", bus.mem_enable_o, 1'b0);
      c_valid[idx] = 1; c_dirty[idx] = 0; c_tag[idx] = tag;
      for (int i = 0; i < 8; i++) c_data[idx][i] = line[i*32 +: 32];
      step();
      chk("post_stall", bus.p1_stall_o, 1'b0);
      chk("post_data", bus.p1_data_o, (served && !w) ? c_data[idx][wsel] : 32'h0);
    end
    if (served && w) begin
      c_data[idx][wsel] = wd;
      c_dirty[idx] = 1;
    end
    step();
    bus.p1_req_i = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    bus.p1_req_i = 0; bus.p1_write_i = 0; bus.p1_addr_i = 0; bus.p1_data_i = 0;
    bus.mem_data_i = '0; bus.mem_ack_i = 0;
    model_clear();
    mem_m[32'h40 >> 2] = 32'hDEAD_BEEF;

    step(); step();
    chk("rst_stall", bus.p1_stall_o, 1'b0);
    chk("rst_data", bus.p1_data_o, 32'h0);
    chk("rst_en", bus.mem_enable_o, 1'b0);
    chk("rst_wr", bus.mem_write_o, 1'b0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    chk("rst_mdata", bus.mem_data_o, 256'h0);
    rst_i = 0;
    step();
    chk("post_rst_stall", bus.p1_stall_o, 1'b0);
    chk("post_rst_data", bus.p1_data_o, 32'h0);

    access(0, 32'h40, 0, 4, 0);
    chk("deadbeef", c_data[2][0], 32'hDEAD_BEEF);
    access(0, 32'h44, 0, 1, 0);
    access(1, 32'h48, 32'h1234_5678, 1, 0);
    access(0, 32'h48, 0, 1, 0);
    chk("dirty2", c_dirty[2], 1'b1);
    access(0, 32'h448, 0, 3, 0);
    chk("evict_mem", mem_m[32'h48 >> 2], 32'h1234_5678);

    // Reset while ALLOCATE waits for its ack.
    bus.p1_req_i = 1; bus.p1_write_i = 0; bus.p1_addr_i = 32'h840;
    #1 chk("rstmid_stall", bus.p1_stall_o, 1'b1);
    step();
    chk("rstmid_alloc", bus.mem_enable_o, 1'b1);
    step();
    rst_i = 1; bus.p1_req_i = 0;
    step();
    chk("rstmid_en", bus.mem_enable_o, 1'b0);
    chk("rstmid_stall0", bus.p1_stall_o, 1'b0);
    rst_i = 0;
    model_clear();
    step();
    chk("rstmid_after", bus.p1_stall_o, 1'b0);
    access(0, 32'h440, 0, 2, 0);

    // Spurious ack in IDLE must not start or disturb anything.
    bus.mem_ack_i = 1;
    step();
    bus.mem_ack_i = 0;
    chk("spur_en", bus.mem_enable_o, 1'b0);
    chk("spur_stall", bus.p1_stall_o, 1'b0);
    access(0, 32'h444, 0, 1, 0);
    access(0, 32'h3E0, 0, 2, 1);
    chk("drop_valid", c_valid[31], 1'b1);
    access(0, 32'h3E4, 0, 1, 0);
    access(0, 32'h0000_0004, 0, 2, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: ra[9:5] = 5'd0;
        1: ra[9:5] = 5'd31;
        default: ra[9:5] = 5'($urandom_range(0, 31));
      endcase
      ra[31:10] = 22'($urandom_range(0, 3));
      ra[4:0]   = {3'($urandom_range(0, 7)), 2'b00};
      access(1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(1, 4), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
